video_pattern_src: RTL and testbench

- Test-pattern video source that drives the per_frame_vsync / per_frame_href / per_frame_clken plus 8-bit R/G/B stream consumed by the pixel-processing blocks (saturation, colour conversion).
- It is the transmitter end of that stream interface. It lets the processing chain run on a board or in simulation without a CMOS sensor.
- It generates frame timing and four selectable patterns; a key press steps the pattern, and each change takes effect at a frame boundary.

---
 rtl/video_stream_pkg.sv | 46 ++++
 rtl/video_pattern_src_if.sv | 20 ++
 rtl/video_timing_gen.sv | 114 +++++++++++
 rtl/video_pattern_src.sv | 163 ++++++++++++++++
 tb/tb_video_pattern_src.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_stream_pkg.sv
// Shared types for the pixel stream: pattern codes, FSM states, RGB payload
// and the colour-bar palette.
package video_stream_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_WHITE   = 24'hFFFFFF;
  localparam rgb_t C_YELLOW  = 24'hFFFF00;
  localparam rgb_t C_CYAN    = 24'h00FFFF;
  localparam rgb_t C_GREEN   = 24'h00FF00;
  localparam rgb_t C_MAGENTA = 24'hFF00FF;
  localparam rgb_t C_RED     = 24'hFF0000;
  localparam rgb_t C_BLUE    = 24'h0000FF;
  localparam rgb_t C_BLACK   = 24'h000000;

  // Bar index 0..7 maps to the palette; 8 (past the last bar) is black.
  function automatic rgb_t bar_colour(input logic [3:0] idx);
    case (idx)
      4'd0:    return C_WHITE;
      4'd1:    return C_YELLOW;
      4'd2:    return C_CYAN;
      4'd3:    return C_GREEN;
      4'd4:    return C_MAGENTA;
      4'd5:    return C_RED;
      4'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_src_if.sv
// Pixel stream bundle: frame/line timing, pixel strobe and 8-bit RGB.
// master drives the stream, slave consumes it.
interface video_pattern_src_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_red, per_img_green, per_img_blue
  );

  modport slave (
    input per_frame_vsync, per_frame_href, per_frame_clken,
    input per_img_red, per_img_green, per_img_blue
  );
endinterface

// File: rtl/video_timing_gen.sv
// Frame timing: pixel-slot divider, h/v counters, IDLE/RUN FSM and the
// combinational timing decode.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_enable          run request, honoured only at frame boundaries
//   o_run_c           FSM is in RUN
//   o_tick_c          pixel-slot strobe (counters advance on it)
//   o_start_c         IDLE->RUN transition this cycle
//   o_frame_start_c   tick at pixel (0,0)
//   o_vsync_c/o_href_c/o_clken_c  timing decode of the current counters
//   o_h_cnt/o_v_cnt   current pixel position
module video_timing_gen
  import video_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_BLANK   = 160,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_BLANK   = 45,
  parameter int unsigned VS_LINES  = 2,
  parameter int unsigned CLKEN_DIV = 1,
  localparam int unsigned H_W = $clog2(H_ACTIVE + H_BLANK),
  localparam int unsigned V_W = $clog2(V_BLANK + V_ACTIVE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_enable,
  output logic           o_run_c,
  output logic           o_tick_c,
  output logic           o_start_c,
  output logic           o_frame_start_c,
  output logic           o_vsync_c,
  output logic           o_href_c,
  output logic           o_clken_c,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;
  localparam int unsigned D_W     = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [D_W-1:0] r_div;
  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;

  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_frame_end;
  logic w_href;
  logic w_vs_line;

  assign w_tick      = (r_state == ST_RUN) && (r_div == D_W'(CLKEN_DIV - 1));
  assign w_h_last    = (r_h == H_W'(H_TOTAL - 1));
  assign w_v_last    = (r_v == V_W'(V_TOTAL - 1));
  assign w_frame_end = w_tick && w_h_last && w_v_last;
  assign w_vs_line   = (r_v < V_W'(VS_LINES));
  assign w_href      = (r_v >= V_W'(V_BLANK)) && (r_h < H_W'(H_ACTIVE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and timing decode; decode is forced low outside RUN
  always_comb begin
    w_state_nxt = r_state;
    o_start_c   = 1'b0;
    o_vsync_c   = 1'b0;
    o_href_c    = 1'b0;
    o_clken_c   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_start_c = i_enable;
        if (i_enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_vsync_c = w_vs_line;
        o_href_c  = w_href;
        o_clken_c = w_tick && w_href;
        if (w_frame_end && !i_enable) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Divider and raster counters; held at zero while idle
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE)) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + D_W'(1);
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + V_W'(1);
        end else begin
          r_h <= r_h + H_W'(1);
        end
      end
    end
  end

  assign o_run_c         = (r_state == ST_RUN);
  assign o_tick_c        = w_tick;
  assign o_frame_start_c = w_tick && (r_h == '0) && (r_v == '0);
  assign o_h_cnt         = r_h;
  assign o_v_cnt         = r_v;

endmodule

// File: rtl/video_pattern_src.sv
// Test-pattern video source. Generates frame timing and one of four patterns
// (bars, gray ramp, checker, solid); a key press steps the pattern at the
// next frame start.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   enable       run request, sampled at frame boundaries
//   key          pattern-step key (debounced upstream)
//   pattern_sel  pattern currently emitted
//   vid          stream master: vsync/href/clken and R/G/B
module video_pattern_src
  import video_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_BLANK     = 45,
  parameter int unsigned VS_LINES    = 2,
  parameter int unsigned CLKEN_DIV   = 1,
  parameter int unsigned CHECK_SHIFT = 5,
  parameter logic [23:0] SOLID_RGB   = 24'h808080
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       key,
  output logic [1:0]                 pattern_sel,
  video_pattern_src_if.master        vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned H_W     = $clog2(H_ACTIVE + H_BLANK);
  localparam int unsigned V_W     = $clog2(V_BLANK + V_ACTIVE);
  localparam int unsigned BW      = H_ACTIVE / 8;
  localparam int unsigned BW_W    = (BW > 1) ? $clog2(BW) : 1;

  logic           w_run_c;
  logic           w_tick_c;
  logic           w_start_c;
  logic           w_frame_start_c;
  logic           w_vsync_c;
  logic           w_href_c;
  logic           w_clken_c;
  logic [H_W-1:0] w_h;
  logic [V_W-1:0] w_v;

  video_timing_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .H_BLANK   (H_BLANK),
    .V_ACTIVE  (V_ACTIVE),
    .V_BLANK   (V_BLANK),
    .VS_LINES  (VS_LINES),
    .CLKEN_DIV (CLKEN_DIV)
  ) u_timing (
    .clk             (clk),
    .rst             (rst),
    .i_enable        (enable),
    .o_run_c         (w_run_c),
    .o_tick_c        (w_tick_c),
    .o_start_c       (w_start_c),
    .o_frame_start_c (w_frame_start_c),
    .o_vsync_c       (w_vsync_c),
    .o_href_c        (w_href_c),
    .o_clken_c       (w_clken_c),
    .o_h_cnt         (w_h),
    .o_v_cnt         (w_v)
  );

  logic      r_key_d;
  logic      r_pending;
  pattern_e  r_pat;
  logic      w_key_rise;
  logic      w_apply;

  assign w_key_rise = key && !r_key_d;
  assign w_apply    = w_start_c || w_frame_start_c;

  // Key edge -> pending step, consumed only at a frame start. An edge on the
  // apply cycle itself survives into pending for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_d   <= 1'b0;
      r_pending <= 1'b0;
      r_pat     <= PAT_BARS;
    end else begin
      r_key_d   <= key;
      r_pending <= w_key_rise || (r_pending && !w_apply);
      if (w_apply && r_pending) r_pat <= pattern_e'(r_pat + 2'd1);
    end
  end

  logic [BW_W-1:0] r_bar_px;
  logic [3:0]      r_bar_idx;

  // Bar position tracked incrementally so no divide by the bar width is needed
  always_ff @(posedge clk) begin
    if (rst || !w_run_c) begin
      r_bar_px  <= '0;
      r_bar_idx <= '0;
    end else if (w_tick_c) begin
      if (w_h == H_W'(H_TOTAL - 1)) begin
        r_bar_px  <= '0;
        r_bar_idx <= '0;
      end else if (w_h < H_W'(H_ACTIVE)) begin
        if (r_bar_px == BW_W'(BW - 1)) begin
          r_bar_px <= '0;
          if (r_bar_idx != 4'd8) r_bar_idx <= r_bar_idx + 4'd1;
        end else begin
          r_bar_px <= r_bar_px + BW_W'(1);
        end
      end
    end
  end

  logic [7:0] w_ramp;
  logic       w_chk_h;
  logic       w_chk_v;
  rgb_t       w_col;

  // Checker bits taken from the pixel column and the active-line index
  assign w_ramp  = 8'(w_h);
  assign w_chk_h = 1'(32'(w_h) >> CHECK_SHIFT);
  assign w_chk_v = 1'((32'(w_v) - 32'(V_BLANK)) >> CHECK_SHIFT);

  // Pattern mux
  always_comb begin
    w_col = C_BLACK;
    case (r_pat)
      PAT_BARS:  w_col = bar_colour(r_bar_idx);
      PAT_RAMP:  w_col = {w_ramp, w_ramp, w_ramp};
      PAT_CHECK: w_col = (w_chk_h ^ w_chk_v) ? C_WHITE : C_BLACK;
      PAT_SOLID: w_col = rgb_t'(SOLID_RGB);
    endcase
  end

  logic r_vsync;
  logic r_href;
  logic r_clken;
  rgb_t r_rgb;

  // All stream outputs registered together, one clock after the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_clken <= 1'b0;
      r_rgb   <= C_BLACK;
    end else begin
      r_vsync <= w_vsync_c;
      r_href  <= w_href_c;
      r_clken <= w_clken_c;
      r_rgb   <= w_href_c ? w_col : C_BLACK;
    end
  end

  assign vid.per_frame_vsync = r_vsync;
  assign vid.per_frame_href  = r_href;
  assign vid.per_frame_clken = r_clken;
  assign vid.per_img_red     = r_rgb.r;
  assign vid.per_img_green   = r_rgb.g;
  assign vid.per_img_blue    = r_rgb.b;
  assign pattern_sel         = r_pat;

endmodule

// File: tb/tb_video_pattern_src.sv
// Bench for video_pattern_src: every clock is checked against a raster model
// derived from the cycle count since RUN began, plus directed timing checks.
module tb_video_pattern_src;

  localparam int HA = 16, HB = 4, VA = 4, VB = 3, VS = 1, DIV = 2, CS = 1;
  localparam int HT = HA + HB, VT = VB + VA;

  logic       clk = 1'b0;
  logic       rst, enable, key;
  logic [1:0] pattern_sel;
  logic [23:0] rgb;

  video_pattern_src_if vif ();

  video_pattern_src #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
    .VS_LINES(VS), .CLKEN_DIV(DIV), .CHECK_SHIFT(CS), .SOLID_RGB(24'h808080)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .key(key),
    .pattern_sel(pattern_sel), .vid(vif)
  );

  always #5 clk = ~clk;

  assign rgb = {vif.per_img_red, vif.per_img_green, vif.per_img_blue};

  int checks = 0;
  int errors = 0;

  // Model state
  bit m_run  = 0;
  int m_t    = 0;
  int m_pat  = 0;
  bit m_pend = 0;
  bit m_keyd = 0;
  int samp   = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] cap [16];
  int cap_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_col(input int pat, input int h, input int v);
    logic [7:0] g;
    int b;
    case (pat)
      0: begin
        b = h / (HA / 8);
        return (b < 8) ? bars[b] : 24'h0;
      end
      1: begin
        g = 8'(h % 256);
        return {g, g, g};
      end
      2: return ((((h >> CS) ^ ((v - VB) >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      default: return 24'h808080;
    endcase
  endfunction

  // One clock: predict outputs from the model, advance, compare.
  task automatic step();
    logic e_vs, e_hr, e_ck;
    logic [23:0] e_rgb;
    bit tk, fs, fe, st;
    int h, v, slot;
    e_vs = 0; e_hr = 0; e_ck = 0; e_rgb = 0;
    tk = 0; fs = 0; fe = 0; st = 0;
    if (rst) begin
      m_run = 0; m_t = 0; m_pat = 0; m_pend = 0; m_keyd = 0;
    end else begin
      if (m_run) begin
        slot  = m_t / DIV;
        tk    = (m_t % DIV) == DIV - 1;
        h     = slot % HT;
        v     = (slot / HT) % VT;
        e_vs  = v < VS;
        e_hr  = (v >= VB) && (h < HA);
        e_ck  = tk && e_hr;
        e_rgb = e_hr ? ref_col(m_pat, h, v) : 24'h0;
        fs    = tk && h == 0 && v == 0;
        fe    = tk && h == HT - 1 && v == VT - 1;
      end else begin
        st = enable;
      end
      if ((st || fs) && m_pend) m_pat = (m_pat + 1) % 4;
      m_pend = (key && !m_keyd) || (m_pend && !(st || fs));
      m_keyd = key;
      if (!m_run) begin m_run = enable; m_t = 0; end
      else if (fe) begin m_run = enable; m_t = 0; end
      else m_t++;
    end
    @(posedge clk);
    #1;
    samp++;
    chk("vsync", 32'(vif.per_frame_vsync), 32'(e_vs));
    chk("href", 32'(vif.per_frame_href), 32'(e_hr));
    chk("clken", 32'(vif.per_frame_clken), 32'(e_ck));
    chk("rgb", 32'(rgb), 32'(e_rgb));
    chk("pattern_sel", 32'(pattern_sel), 32'(m_pat));
  endtask

  // Advance until the model sits at the first clock of pixel (0,line).
  task automatic run_to(input int line);
    int n = 0;
    while (!(m_run && (m_t % DIV) == 0 && ((m_t / DIV) % HT) == 0 &&
             ((m_t / DIV) / HT) % VT == line) && n < 2000) begin
      step();
      n++;
    end
    chk("run_to_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic capture(input int line);
    run_to(line);
    cap_n = 0;
    repeat (DIV * HT) begin
      step();
      if (vif.per_frame_clken === 1'b1 && cap_n < 16) begin
        cap[cap_n] = rgb;
        cap_n++;
      end
    end
    chk("cap_count", 32'(cap_n), 32'd16);
  endtask

  task automatic key_pulse();
    key = 1'b1; step();
    key = 1'b0; step();
  endtask

  initial begin
    int vs_clks, hr_pulses, hr_len, ck_cnt, ck_line, last_ck, n;
    int vs_rise[$];
    logic prev_hr, prev_vs;

    rst = 1'b1; enable = 1'b0; key = 1'b0;
    step(); step();
    chk("reset_out", 32'({vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken, rgb}), 32'd0);

    // First frame: timing measurements
    rst = 1'b0; enable = 1'b1;
    step();
    vs_clks = 0; hr_pulses = 0; hr_len = 0; ck_cnt = 0; ck_line = 0; last_ck = -10;
    prev_hr = 1'b0; prev_vs = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (vif.per_frame_vsync && !prev_vs) vs_rise.push_back(samp);
      if (k <= 280) begin
        if (vif.per_frame_vsync) vs_clks++;
        if (vif.per_frame_href) begin
          if (!prev_hr) hr_pulses++;
          hr_len++;
          if (vif.per_frame_clken) begin
            ck_line++;
            if (ck_line > 1) chk("clken_gap", 32'(samp - last_ck), 32'd2);
            last_ck = samp;
          end
        end else if (prev_hr) begin
          chk("href_len", 32'(hr_len), 32'd32);
          chk("clken_per_line", 32'(ck_line), 32'd16);
          hr_len = 0; ck_line = 0;
        end
        if (vif.per_frame_clken) ck_cnt++;
      end
      prev_hr = vif.per_frame_href;
      prev_vs = vif.per_frame_vsync;
    end
    chk("vsync_clks", 32'(vs_clks), 32'd40);
    chk("href_pulses", 32'(hr_pulses), 32'd4);
    chk("clken_total", 32'(ck_cnt), 32'd64);
    chk("vsync_rises", 32'(vs_rise.size()), 32'd2);
    chk("frame_period", 32'((vs_rise.size() >= 2) ? vs_rise[1] - vs_rise[0] : 0), 32'd280);

    // Colour bars on the first active line
    capture(VB);
    for (int i = 0; i < 16; i++) chk("bar_px", 32'(cap[i]), 32'(bars[i / 2]));

    // Key mid-frame steps only at the next frame start
    run_to(5);
    key_pulse();
    chk("pat_hold", 32'(pattern_sel), 32'd0);
    run_to(0); step(); step();
    chk("pat_step1", 32'(pattern_sel), 32'd1);
    capture(VB);
    for (int i = 0; i < 16; i++) chk("ramp_px", 32'(cap[i]), 32'({3{8'(i)}}));

    // Three edges in one frame merge into one step
    run_to(4);
    for (int i = 0; i < 3; i++) begin
      key_pulse();
      repeat ($urandom_range(1, 6)) step();
    end
    run_to(0); step(); step();
    chk("pat_merge", 32'(pattern_sel), 32'd2);
    capture(VB);
    for (int i = 0; i < 16; i++)
      chk("check_l0", 32'(cap[i]), ((i >> 1) & 1) != 0 ? 32'hFFFFFF : 32'h0);
    capture(VB + 2);
    for (int i = 0; i < 16; i++)
      chk("check_l2", 32'(cap[i]), ((i >> 1) & 1) != 0 ? 32'h0 : 32'hFFFFFF);
    run_to(6);
    key_pulse();
    run_to(0); step(); step();
    chk("pat_step3", 32'(pattern_sel), 32'd3);
    capture(VB);
    for (int i = 0; i < 16; i++) chk("solid_px", 32'(cap[i]), 32'h808080);
    run_to(5);
    key_pulse();
    run_to(0); step(); step();
    chk("pat_wrap", 32'(pattern_sel), 32'd0);

    // Edge on the frame-start tick itself defers to the next frame
    run_to(0);
    step();
    key = 1'b1; step();
    key = 1'b0;
    chk("pat_same_cycle", 32'(pattern_sel), 32'd0);
    run_to(0); step(); step();
    chk("pat_deferred", 32'(pattern_sel), 32'd1);

    // Random key activity across several frames
    repeat (3 * 280) begin
      key = ($urandom_range(0, 29) == 0);
      step();
    end
    key = 1'b0;

    // Enable drop mid-frame: frame completes, then idle
    run_to(4);
    repeat ($urandom_range(0, 30)) step();
    enable = 1'b0;
    repeat (400) step();
    chk("idle_out", 32'({vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken, rgb}), 32'd0);
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!vif.per_frame_vsync && n < 10);
    chk("vsync_latency", 32'(n), 32'd2);

    // Reset during href with a step pending
    run_to(4);
    repeat (5) step();
    chk("href_before_rst", 32'(vif.per_frame_href), 32'd1);
    key_pulse();
    rst = 1'b1; step();
    chk("rst_href", 32'(vif.per_frame_href), 32'd0);
    chk("rst_pat", 32'(pattern_sel), 32'd0);
    rst = 1'b0;
    run_to(VB);
    chk("pending_cleared", 32'(pattern_sel), 32'd0);
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
